instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs operation, register and immediate fields into 32-bit RV32I instruction words for the datapath's supported subset (add, sll, andi, lh, sh, bne).
- Streams encoded words into instruction memory through a write port, with an auto-incrementing address.
- Used as the bench/boot-time program loader ahead of the single-cycle datapath.
- Range-checks every immediate and rejects unencodable requests.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr.
- BASE_ADDR, 0, first write address after reset or clear; must be 4-aligned.
- MAX_INSTR, 64, capacity in words; writes stop when count reaches it.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; one clock domain.
- clear  input  1  synchronous restart of address/count; priority over all other inputs.
- in_valid  input  1  request present.
- in_ready  output  1  request can be accepted this cycle.
- op  input  3  0=ADD 1=SLL 2=ANDI 3=LH 4=SH 5=BNE; 6,7 illegal.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- imm  input  32  signed immediate; byte offset for BNE.
- mem_we  output  1  write strobe, held until accepted.
- mem_ready  input  1  memory accepts the write when high together with mem_we.
- mem_addr  output  ADDR_WIDTH  byte address of the current write.
- mem_wdata  output  32  encoded instruction.
- count  output  8  words written since reset or clear.
- full  output  1  count == MAX_INSTR.
- err  output  1  one-cycle pulse marking a rejected request.

Behaviour:
- Reset (async) and clear (sync): state IDLE; mem_we=0; mem_wdata=0; mem_addr=BASE_ADDR; count=0; err=0.
- Clear during WRITE aborts the pending write; no count increment.
- States:
  - IDLE: in_ready = !full.
    - Acceptance occurs when in_valid && in_ready.
    - Legal request: register the encoded word into mem_wdata and go to WRITE.
    - Illegal request: err=1 on the next cycle, stay in IDLE, nothing written.
  - WRITE: in_ready=0, mem_we=1, mem_addr and mem_wdata stable.
    - On mem_ready: mem_addr += 4, count += 1, return to IDLE; mem_we drops the next cycle.
  - Minimum 2 cycles per word; mem_ready tied high gives mem_we on the cycle after acceptance.
- Encoding, fields as given:
  - ADD: {7'b0, rs2, rs1, 000, rd, 0110011}.
  - SLL: same as ADD with funct3=001.
  - ANDI: {imm[11:0], rs1, 111, rd, 0010011}.
  - LH: {imm[11:0], rs1, 001, rd, 0000011}.
  - SH: {imm[11:5], rs2, rs1, 001, imm[4:0], 0100011}.
  - BNE: {imm[12], imm[10:5], rs2, rs1, 001, imm[4:1], imm[11], 1100011}.
  - Unused fields are ignored; e.g. rs2 for ANDI, rd for SH.
- Illegal requests, all flagged via err:
  - op 6 or 7.
  - ANDI, LH, SH with imm outside -2048..2047.
  - BNE with imm outside -4096..4094, or imm[0]=1.
- Full: in_ready=0 until reset or clear; in_valid is ignored and no err is raised.
- mem_addr wraps modulo 2^ADDR_WIDTH with no error.
- in_valid is ignored while in WRITE; the requester must hold its request until in_ready.

Test Plan:
- Reset then ANDI rd=3 rs1=2 imm=1, mem_ready=1 -> mem_we one cycle, mem_addr=0, mem_wdata=0x00117193, count=1.
- LH rd=3 rs1=2 imm=1, then SH rs1=5 rs2=6 imm=4 -> words 0x00111183 @0 and 0x00629223 @4.
- BNE rs1=1 rs2=2 imm=-4 with mem_ready low 3 cycles -> mem_we/addr/wdata=0xFE209EE3 held for 4 cycles, count increments once.
- ADD then SLL, rd=3 rs1=1 rs2=2 -> 0x002081B3, then 0x002091B3; BNE imm=3 -> err pulse, no write; ANDI imm=2048 -> err pulse, count unchanged.
- MAX_INSTR=2: three legal requests -> full=1 after the second, in_ready=0, third never written; clear -> count=0, mem_addr=BASE_ADDR, in_ready=1.
- Assert reset mid-WRITE -> mem_we=0, count=0, mem_addr=BASE_ADDR immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for the RV32I program loader.
// The encoder takes the master view; the requester/memory side takes the slave view.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [31:0]           imm;
  logic                  mem_we;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [7:0]            count;
  logic                  full;
  logic                  err;

  modport master (
    input  in_valid, op, rd, rs1, rs2, imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );

  modport slave (
    output in_valid, op, rd, rs1, rs2, imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs add/sll/andi/lh/sh/bne requests into RV32I words and streams them
// into instruction memory at an auto-incrementing byte address.
module instr_encoder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_INSTR  = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  instr_encoder_if.master bus
);
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SLL  = 3'd1;
  localparam logic [2:0] OP_ANDI = 3'd2;
  localparam logic [2:0] OP_LH   = 3'd3;
  localparam logic [2:0] OP_SH   = 3'd4;
  localparam logic [2:0] OP_BNE  = 3'd5;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [7:0]            count_q;
  logic                  full_w;
  logic                  ready_w;
  logic signed [31:0]    imm_s;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic is_legal(input logic [2:0] op, input logic signed [31:0] imm);
    case (op)
      OP_ADD, OP_SLL:        is_legal = 1'b1;
      OP_ANDI, OP_LH, OP_SH: is_legal = in_range(imm, -32'sd2048, 32'sd2047);
      OP_BNE:                is_legal = in_range(imm, -32'sd4096, 32'sd4094) && !imm[0];
      default:               is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic signed [31:0] imm);
    case (op)
      OP_ADD:  encode = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_SLL:  encode = {7'b0, rs2, rs1, 3'b001, rd, 7'b0110011};
      OP_ANDI: encode = {imm[11:0], rs1, 3'b111, rd, 7'b0010011};
      OP_LH:   encode = {imm[11:0], rs1, 3'b001, rd, 7'b0000011};
      OP_SH:   encode = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b0100011};
      // B-type scatters the halfword offset; bit 0 is implicit.
      OP_BNE:  encode = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
      default: encode = '0;
    endcase
  endfunction

  assign imm_s   = signed'(bus.imm);
  assign full_w  = (count_q == 8'(MAX_INSTR));
  assign ready_w = (state == IDLE) && !full_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && ready_w) begin
            if (is_legal(bus.op, imm_s)) begin
              wdata_q <= encode(bus.op, bus.rd, bus.rs1, bus.rs2, imm_s);
              we_q    <= 1'b1;
              state   <= WRITE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Address wraps naturally at 2^ADDR_WIDTH.
          if (bus.mem_ready) begin
            addr_q  <= addr_q + ADDR_WIDTH'(4);
            count_q <= count_q + 8'd1;
            we_q    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_w;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.err       = err_q;
endmodule
